// File: rtl/dist_ram_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO on the SD-card read path.
// Defaults size the buffer for 512-bit words, 256 deep.
package dist_ram_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    localparam int DEFAULT_RAM_WIDTH     = 512;
    localparam int DEFAULT_RAM_DEPTH     = 256;
    localparam int DEFAULT_RAM_ADDR_BITS = clog2(DEFAULT_RAM_DEPTH);

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0
    };

endpackage

// File: rtl/dual_async_distributed_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// Contents are never reset so the array maps onto LUT RAM.
module dual_async_distributed_ram #(
    parameter int RAM_WIDTH     = 512,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic [RAM_ADDR_BITS-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]     wr_data,
    input  logic                     wr_enb,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic [RAM_WIDTH-1:0]     rd_data
);

    localparam int DEPTH = 2**RAM_ADDR_BITS;

    (* ram_style = "distributed" *) logic [RAM_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_enb) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dist_ram_fifo.sv
// First-word-fall-through FIFO over distributed RAM with fill count, threshold flags,
// sticky overflow/underflow and a synchronous flush.
module dist_ram_fifo
    import dist_ram_pkg::*;
#(
    parameter int RAM_WIDTH     = DEFAULT_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = DEFAULT_RAM_ADDR_BITS,
    parameter int AFULL_THRESH  = 2**RAM_ADDR_BITS - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [RAM_WIDTH-1:0]   wr_data,
    input  logic                   rd_en,
    output logic [RAM_WIDTH-1:0]   rd_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [RAM_ADDR_BITS:0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                 CNT_W     = RAM_ADDR_BITS + 1;
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(2**RAM_ADDR_BITS);

    logic [RAM_ADDR_BITS-1:0] wr_ptr;
    logic [RAM_ADDR_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_next;
    fifo_flags_t              flags;
    logic                     ovf_sticky;
    logic                     udf_sticky;

    logic push_acc;
    logic pop_acc;
    logic ovf_event;
    logic udf_event;

    function automatic fifo_flags_t flags_for(input logic [CNT_W-1:0] n);
        fifo_flags_t f;
        f.empty        = (n == '0);
        f.full         = (n == DEPTH_CNT);
        f.almost_empty = (int'(n) <= AEMPTY_THRESH);
        f.almost_full  = (int'(n) >= AFULL_THRESH);
        return f;
    endfunction

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
    assign push_acc  = !clr && wr_en && (!flags.full || rd_en);
    assign pop_acc   = !clr && rd_en && !flags.empty;
    assign ovf_event = !clr && wr_en && flags.full && !rd_en;
    assign udf_event = !clr && rd_en && flags.empty;

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (push_acc && !pop_acc) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            flags      <= FLAGS_RESET;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            flags      <= FLAGS_RESET;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + RAM_ADDR_BITS'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + RAM_ADDR_BITS'(1);
            end
            cnt   <= cnt_next;
            flags <= flags_for(cnt_next);
            if (ovf_event) begin
                ovf_sticky <= 1'b1;
            end
            if (udf_event) begin
                udf_sticky <= 1'b1;
            end
        end
    end

    // Head word falls through from the asynchronous read port at rd_ptr.
    dual_async_distributed_ram #(
        .RAM_WIDTH     (RAM_WIDTH),
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .wr_enb  (push_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign empty        = flags.empty;
    assign full         = flags.full;
    assign almost_empty = flags.almost_empty;
    assign almost_full  = flags.almost_full;
    assign count        = cnt;
    assign overflow     = ovf_sticky;
    assign underflow    = udf_sticky;

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Bench for dist_ram_fifo at 8 x 16: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with flushes.
module tb_dist_ram_fifo;

    localparam int W     = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk;
    logic          reset_n;
    logic          clr;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AB:0]   count;
    logic          overflow;
    logic          underflow;

    int n_cmp;
    int n_err;
    bit chk_en;

    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_udf;

    dist_ram_fifo #(
        .RAM_WIDTH     (W),
        .RAM_ADDR_BITS (AB),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue length, stickies follow the push/pop rules.
    initial begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else if (clr) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                bit was_full;
                bit was_empty;
                was_full  = (mq.size() == DEPTH);
                was_empty = (mq.size() == 0);
                if (rd_en && was_empty) m_udf = 1'b1;
                if (wr_en && was_full && !rd_en) m_ovf = 1'b1;
                if (rd_en && !was_empty) void'(mq.pop_front());
                if (wr_en && (!was_full || rd_en)) mq.push_back(wr_data);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int sz;
                sz = mq.size();
                check("count",        32'(count),        32'(sz));
                check("empty",        32'(empty),        32'(sz == 0));
                check("full",         32'(full),         32'(sz == DEPTH));
                check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
                check("almost_full",  32'(almost_full),  32'(sz >= AF));
                check("overflow",     32'(overflow),     32'(m_ovf));
                check("underflow",    32'(underflow),    32'(m_udf));
                if (sz > 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
            end
        end
    end

    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] next_push;
        logic [W-1:0] next_pop;
        int           pushed;
        n_cmp   = 0;
        n_err   = 0;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        step(0, 8'h00, 0, 0);

        for (int i = 1; i <= 16; i++) begin
            step(1, W'(i), 0, 0);
            if (i == 1) begin
                check("first_word", 32'(rd_data), 32'h01);
                check("first_nonempty", 32'(empty), 0);
            end
            if (i == 11) check("afull_at11", 32'(almost_full), 0);
            if (i == 12) check("afull_at12", 32'(almost_full), 1);
        end
        check("full_at16", 32'(full), 1);
        check("count_at16", 32'(count), 16);
        step(1, 8'hAA, 0, 0);
        check("ovf_dropped", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        for (int i = 1; i <= 16; i++) begin
            check("drain_order", 32'(rd_data), 32'(i));
            step(0, 8'h00, 1, 0);
        end
        check("drained_empty", 32'(empty), 1);

        step(0, 8'h00, 0, 1);
        check("clr_ovf", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) step(1, 8'h20 + W'(i), 0, 0);
        check("sim_old_head", 32'(rd_data), 32'h20);
        step(1, 8'h55, 1, 0);
        check("sim_count", 32'(count), 16);
        check("sim_no_ovf", 32'(overflow), 0);
        check("sim_new_head", 32'(rd_data), 32'h21);
        for (int i = 0; i < 16; i++) begin
            check("sim_drain", 32'(rd_data), (i == 15) ? 32'h55 : 32'(8'h21 + W'(i)));
            step(0, 8'h00, 1, 0);
        end

        step(0, 8'h00, 1, 0);
        check("udf_set", 32'(underflow), 1);
        check("udf_count", 32'(count), 0);
        step(1, 8'h33, 1, 0);
        check("udf_push_count", 32'(count), 1);
        check("udf_push_data", 32'(rd_data), 32'h33);
        step(0, 8'h00, 1, 0);

        // Wrap: occupancy held in 3..5 while 40 words stream through.
        step(0, 8'h00, 0, 1);
        next_push = 8'h40;
        next_pop  = 8'h40;
        pushed    = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, next_push, 0, 0);
            next_push++;
            pushed++;
        end
        for (int k = 0; k < 400 && pushed < 44; k++) begin
            int  sz;
            logic w;
            logic r;
            sz = mq.size();
            if (sz >= 5) begin
                w = 1'b0; r = 1'b1;
            end else if (sz <= 3) begin
                w = 1'b1; r = ($urandom_range(0, 1) == 1) && (sz == 3);
            end else begin
                w = ($urandom_range(0, 1) == 1);
                r = ($urandom_range(0, 1) == 1);
            end
            if (r) begin
                check("wrap_data", 32'(rd_data), 32'(next_pop));
                next_pop++;
            end
            step(w, next_push, r, 0);
            if (w) begin
                next_push++;
                pushed++;
            end
        end
        check("wrap_pushed", 32'(pushed), 44);

        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 17; i++) step(1, W'(i), 0, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0);
        check("pre_clr_count", 32'(count), 9);
        check("pre_clr_ovf", 32'(overflow), 1);
        step(1, 8'h77, 1, 1);
        check("clr_count", 32'(count), 0);
        check("clr_empty", 32'(empty), 1);
        check("clr_ovf0", 32'(overflow), 0);
        check("clr_udf0", 32'(underflow), 0);

        for (int i = 0; i < 6; i++) step(1, 8'h90 + W'(i), 0, 0);
        wr_en = 1'b1;
        rd_en = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("async_count", 32'(count), 0);
        check("async_empty", 32'(empty), 1);
        check("async_aempty", 32'(almost_empty), 1);
        check("async_full", 32'(full), 0);
        check("async_afull", 32'(almost_full), 0);
        check("async_ovf", 32'(overflow), 0);
        check("async_udf", 32'(underflow), 0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 8'h00, 0, 0);
        check("post_rst_empty", 32'(empty), 1);

        for (int k = 0; k < 800; k++) begin
            int wp;
            int rp;
            case (k / 200)
                0:       begin wp = 70; rp = 30; end
                1:       begin wp = 30; rp = 70; end
                2:       begin wp = 50; rp = 50; end
                default: begin wp = 90; rp = 90; end
            endcase
            step($urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) < rp,
                 $urandom_range(0, 63) == 0);
        end
        step(0, 8'h00, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dist_ram_fifo.md
# dist_ram_fifo

Parametrised synchronous FIFO built on distributed RAM, the next generation of our single-port asynchronous-read RAM for the SD-card read path. It buffers wide data words between the SD block reader and downstream consumers. It presents first-word-fall-through read data straight from the RAM's asynchronous read port. It adds fill tracking, threshold flags, sticky error flags and a synchronous flush.

## Interface
Parameters:
- RAM_WIDTH, 512, data word width in bits
- RAM_ADDR_BITS, 8, address width; depth = 2**RAM_ADDR_BITS
- AFULL_THRESH, 2**RAM_ADDR_BITS-4, almost_full asserts when count >= this
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush, highest priority
- wr_en  in  1  push request
- wr_data  in  RAM_WIDTH  push data
- rd_en  in  1  pop request (acknowledges current rd_data)
- rd_data  out  RAM_WIDTH  head word, combinational from RAM, valid when !empty
- empty  out  1  registered
- full  out  1  registered
- almost_empty  out  1  registered
- almost_full  out  1  registered
- count  out  RAM_ADDR_BITS+1  registered occupancy, 0..2**RAM_ADDR_BITS
- overflow  out  1  sticky: push dropped while full
- underflow  out  1  sticky: pop requested while empty

## Operation
- Storage: 2**RAM_ADDR_BITS x RAM_WIDTH with a synchronous write port at wr_ptr and an asynchronous read port at rd_ptr. Memory contents are never reset.
- Pointers wr_ptr and rd_ptr are RAM_ADDR_BITS wide and wrap modulo depth with no special casing.
- Accepted push: wr_en && (!full || rd_en). The word is written at wr_ptr and wr_ptr increments.
- Accepted pop: rd_en && !empty. rd_ptr increments.
- Push while full with no pop: the word is dropped and overflow sets. Pop while empty: ignored and underflow sets. A simultaneous push is still accepted.
- Push and pop in the same cycle when full: both are accepted. The old head is read combinationally before the edge overwrites it. Count stays at depth.
- Push and pop both accepted in the same cycle: count is unchanged.
- count_next = count + push_acc - pop_acc.
- empty, full and both almost flags are registered from count_next, so they always agree with count.
- clr: pointers and count go to 0 and overflow/underflow clear. Flags take their reset values. Any same-cycle wr_en/rd_en is ignored and does not set the sticky flags.
- Sticky flags clear only on reset_n or clr.

## Timing
- Reset (reset_n low, asynchronous) values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, pointers 0.
- rd_data is don't-care while empty.
- Write-to-read latency is 1 cycle: a word pushed into an empty FIFO at edge N is visible on rd_data with empty=0 after edge N.
- Pop takes effect at the edge. The next word appears on rd_data combinationally after that edge.
- All flags update on the same edge as count. There are no combinational paths from wr_en/rd_en to any flag.
- rd_data depends combinationally only on rd_ptr and RAM contents, never on rd_en.
- reset_n deasserting mid-stream: the FIFO restarts empty. Stale RAM contents are unreachable until rewritten.

## Structure
- Shared header/package dist_ram_pkg:
  - clog2 function.
  - default width/depth constants for the SD read path (512 x 256).
- Sub-module dual_async_distributed_ram:
  - Parameters RAM_WIDTH, RAM_ADDR_BITS.
  - Ports clk, wr_addr, wr_data, wr_enb, rd_addr, rd_data.
  - Synchronous write, asynchronous read, RAM_STYLE distributed attribute.
- dist_ram_fifo holds only the pointers, counter, flags and accept logic.

## Test plan
Run with RAM_WIDTH=8, RAM_ADDR_BITS=4 (depth 16), AFULL_THRESH=12, AEMPTY_THRESH=4.
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
- Push 0x01..0x10 (16 words):
  - After the 1st edge: rd_data=0x01, empty=0.
  - After the 12th edge: almost_full=1.
  - After the 16th edge: full=1, count=16.
  - A 17th push of 0xAA is dropped and overflow=1. Popping all 16 returns 0x01..0x10 in order, then empty=1.
- Full FIFO with simultaneous push 0x55 and pop: the popped word is the old head, count stays 16, no overflow. The 0x55 is read out last.
- Pop on empty: underflow=1 and count stays 0. Simultaneous push 0x33 with that pop: count=1, rd_data=0x33.
- Wrap test: push/pop 40 words continuously at an occupancy of 3 to 5. The data sequence is intact and almost_empty tracks count<=4 each cycle.
- clr with count=9 and overflow=1, with wr_en=rd_en=1 in the same cycle:
  - Next cycle: count=0, empty=1, overflow=0, underflow=0.
  - reset_n pulsed low mid-burst: outputs return to reset values immediately, without waiting for a clk edge.
